// File: rtl/serial_add_unit_if.sv
// Handshake bundle for the bit-serial add/subtract unit.
// The master side supplies operands and accepts results, and the slave side is the unit itself.
interface serial_add_unit_if #(
  parameter int WIDTH = 32
);
  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract engine.
// One full adder and a registered carry process a single operand bit per clock, LSB first.
// A subtract is done as A + ~B + 1: B is inverted at capture, and the carry is seeded with 1.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only WIDTH-1 partial sum bits are stored. The last bit goes directly into result on the final edge.
  logic [WIDTH-2:0] sum_sh;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             overflow_q;
  logic             zero_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] next_sum;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // The current sum bit enters at the MSB, so after WIDTH shifts the LSB has reached bit 0.
  assign next_sum = {fa_s, sum_sh};

  // Control FSM, datapath shift registers, and registered outputs
  // NOTE: all state in this block uses non-blocking assignments, so every right-hand side reads the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the reset also clears the shift registers and carry, so an operation cut short by reset leaves no partial state behind.
      state       <= IDLE;
      counter     <= '0;
      carry       <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.sub ? ~bus.b : bus.b;
            carry      <= bus.sub;
            counter    <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end

        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= next_sum[WIDTH-1:1];
          carry   <= fa_c;
          counter <= counter + CNT_W'(1);
          if (counter == LAST_BIT) begin
            // Here carry holds the carry into the MSB, and fa_c is the carry out of it.
            result_q    <= next_sum;
            cout_q      <= fa_c;
            overflow_q  <= carry ^ fa_c;
            zero_q      <= (next_sum == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed testbench for serial_add_unit.
// Expected values are hand computed. Outputs are sampled 1 ns after each rising edge.
module tb_serial_add_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_unit_if #(.WIDTH(WIDTH)) bus ();

  serial_add_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present the operands in IDLE and take them on the next edge (E0).
  // The operands are then scrambled to show that the unit uses only the values it captured.
  task automatic accept(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.sub      = sv;
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = bv ^ 32'hA5A5_5A5A;
    bus.sub      = ~sv;
    check("accept_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
  endtask

  // Wait for out_valid after E0 and check the latency, the RUN handshake, and the result and flags.
  task automatic wait_done(input string tag, input logic [31:0] er, input logic ec,
                           input logic eo, input logic ez);
    int  cyc      = 0;
    bit  rdy_seen = 1'b0;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
      if (bus.in_ready) rdy_seen = 1'b1;
    end
    check({tag, "_latency"}, cyc, 32'd32);
    check({tag, "_ready_low_run"}, {31'd0, rdy_seen}, 32'd0);
    check({tag, "_result"}, bus.result, er);
    check({tag, "_flags"}, {29'd0, bus.cout, bus.overflow, bus.zero}, {29'd0, ec, eo, ez});
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int          acc_idx[$];
    logic [31:0] res_q[$];
    bit          prev_rdy;
    bit          spurious;
    int          drain;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {29'd0, bus.cout, bus.overflow, bus.zero}, 32'd0);

    // Latency and basic add: 5 + 3
    accept(32'd5, 32'd3, 1'b0);
    wait_done("add_5_3", 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    tick();
    check("done_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    check("done_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    release_result();

    // Unsigned wrap
    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    release_result();

    // Signed overflow, positive and negative
    accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("ovf_pos", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    release_result();
    accept(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done("ovf_neg", 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    release_result();

    // Subtract
    accept(32'd5, 32'd5, 1'b1);
    wait_done("sub_5_5", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    release_result();
    accept(32'd3, 32'd5, 1'b1);
    wait_done("sub_3_5", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    release_result();
    accept(32'h1234_5678, 32'd0, 1'b1);
    wait_done("sub_b0", 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    release_result();

    // Backpressure: hold DONE for 10 cycles while new operands are offered
    accept(32'd10, 32'd20, 1'b0);
    wait_done("bp_first", 32'd30, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 32'd100;
    bus.b        = 32'd200;
    bus.sub      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_result", bus.result, 32'd30);
      check("bp_no_accept", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_exit_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_exit_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check("bp_next_accept", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0BAD_F00D;
    wait_done("bp_second", 32'd300, 1'b0, 1'b0, 1'b0);
    release_result();

    // Continuous in_valid with out_ready held high gives one accept every WIDTH+2 cycles
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.a         = 32'd1;
    bus.b         = 32'd2;
    bus.sub       = 1'b0;
    prev_rdy      = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (prev_rdy && !bus.in_ready) begin
        acc_idx.push_back(i);
        bus.a = 32'd4;
        bus.b = 32'd4;
      end
      if (bus.out_valid) res_q.push_back(bus.result);
      prev_rdy = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    check("tp_accept_count", acc_idx.size(), 32'd3);
    if (acc_idx.size() >= 2) check("tp_gap", acc_idx[1] - acc_idx[0], 32'd34);
    check("tp_result_count", res_q.size(), 32'd2);
    if (res_q.size() >= 2) begin
      check("tp_result0", res_q[0], 32'd3);
      check("tp_result1", res_q[1], 32'd8);
    end
    drain = 0;
    while (!bus.in_ready && drain < 50) begin
      tick();
      drain++;
    end
    check("tp_drain_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;

    // Leave non-zero flags in place before the mid-RUN reset
    accept(32'h8000_0000, 32'd1, 1'b1);
    wait_done("sub_min_1", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    release_result();

    // Mid-RUN reset at bit 10
    accept(32'h0000_FFFF, 32'd1, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_result", bus.result, 32'd0);
    check("mrst_flags", {29'd0, bus.cout, bus.overflow, bus.zero}, 32'd0);
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) spurious = 1'b1;
    end
    check("mrst_no_spurious", {31'd0, spurious}, 32'd0);
    accept(32'd7, 32'd9, 1'b0);
    wait_done("after_rst", 32'd16, 1'b0, 1'b0, 1'b0);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
- Bit-serial add/subtract engine for the 32-bit ALU datapath.
- Adds two WIDTH-bit operands one bit per clock, using a single full_adder instance with a registered carry.
- Sits between the operand-select stage and the ALU result/flag register. It is the low-area alternative to the ripple adder chain.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width in bits (must be ≥2).
- CNT_W, 6, width of the bit counter (must satisfy 2^CNT_W > WIDTH).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B (A + ~B + 1).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  sum/difference.
- cout  output  1  carry out of the MSB (for sub, 1 = no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset: on clk edge with rst=1:
  - state=IDLE, counter=0, carry reg=0.
  - Shift registers cleared.
  - in_ready=1, out_valid=0, result=0, cout=0, overflow=0, zero=0.
  - rst has priority over every other input in every state, including mid-RUN: the operation is discarded and no out_valid is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: capture a into a_sh, capture (sub ? ~b : b) into b_sh, carry ← sub, counter ← 0, go to RUN.
  - This acceptance edge is E0.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge: the full_adder computes s, c from a_sh[0], b_sh[0], carry.
  - s shifts into the MSB of the sum shift register; a_sh and b_sh shift right one bit; carry ← c; counter increments.
  - On the edge where counter == WIDTH−1 (edge E_WIDTH), the MSB bit is processed and the FSM goes to DONE.
  - Output registers load on that same edge:
    - result = final sum register.
    - cout = c of the MSB bit.
    - overflow = (carry into MSB) XOR (c of MSB).
    - zero = (final sum == 0).
- DONE:
  - out_valid=1, in_ready=0.
  - result and flags are held stable while out_valid=1.
  - On out_ready=1: go to IDLE and drop out_valid on that edge.
  - in_valid is not accepted in the same cycle; the next accept is possible on the following edge at the earliest.
- Latency:
  - out_valid rises exactly WIDTH cycles after the acceptance edge E0.
  - Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- Output update rule:
  - result and flags change only on entry to DONE or on reset; they hold their values in IDLE and RUN.
  - out_valid changes only on DONE entry, DONE exit, or reset.
- Arithmetic:
  - Modulo 2^WIDTH; no saturation.
  - sub with b=0 yields cout=1.
- Boundary conditions:
  - out_ready held high before DONE has no effect.
  - in_valid held high continuously: a new operation is accepted every WIDTH+2 cycles, always using the a/b values present on the acceptance edge.
  - Operands changing during RUN do not affect the result.

Test Plan:
- Latency: rst pulse, then a=5, b=3, sub=0 -> result=0x00000008, cout=0, overflow=0, zero=0; out_valid rises exactly 32 cycles after the accept edge; in_ready=0 throughout RUN/DONE.
- Unsigned wrap: a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0x00000000, cout=1, zero=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> result=0x80000000, overflow=1, cout=0; a=0x80000000, b=0x80000000 -> result=0, cout=1, overflow=1, zero=1.
- Subtract: a=5, b=5, sub=1 -> result=0, cout=1, zero=1; a=3, b=5, sub=1 -> result=0xFFFFFFFE, cout=0, overflow=0.
- Backpressure: complete an op with out_ready=0 for 10 cycles while in_valid=1 with new operands -> out_valid stays 1, result/flags unchanged, no new accept. Raise out_ready -> IDLE next edge, new op accepted on the following edge.
- Mid-RUN reset: assert rst at bit 10 of an add -> next edge state IDLE, in_ready=1, out_valid=0, all outputs 0, no spurious out_valid. A subsequent 7+9 -> result=16.
